// File: rtl/par_stats_sink_pkg.sv
// Flit layout, field offsets and LFSR helpers shared by the par_stats_sink files.
// HDR_SZ/PL_SZ/ADDR_SZ may be overridden on the command line; defaults suit the 3x3 bench.
`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 32
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef ADDR_LSB
`define ADDR_LSB 0
`endif
`ifndef PL_LSB
`define PL_LSB (`ADDR_SZ)
`endif
`ifndef HDR_LSB
`define HDR_LSB (`ADDR_SZ + `PL_SZ)
`endif

package par_stats_sink_pkg;

    localparam int HDR_SZ   = `HDR_SZ;
    localparam int PL_SZ    = `PL_SZ;
    localparam int ADDR_SZ  = `ADDR_SZ;
    localparam int FLIT_W   = HDR_SZ + PL_SZ + ADDR_SZ;

    localparam int ADDR_LSB = `ADDR_LSB;
    localparam int PL_LSB   = `PL_LSB;
    localparam int HDR_LSB  = `HDR_LSB;

    // Polynomial x^8 + x^6 + x^5 + x^4 + 1: taps 8,6,5,4 map to bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/sink_fifo.sv
// Circular flit buffer for par_stats_sink; pointers wrap modulo DEPTH (power of 2),
// head entry is readable combinationally, pointers and count clear on async reset.
module sink_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_LVL);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/par_stats_sink.sv
// Router ejection-port sink: buffers flits, drains them at an LFSR-gated rate, checks the
// destination address and keeps saturating stats. Define SINK_LATENCY_EN for latency stats.
module par_stats_sink
    import par_stats_sink_pkg::*;
#(
    parameter int ID        = 0,
    parameter int SINK_HOSP = 255,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 20,
    localparam int OCC_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] data_in,
    input  logic              valid_in,
    output logic              busy_out,
    output logic [FLIT_W-1:0] flit_out,
    output logic              flit_valid,
    output logic [CNT_W-1:0]  rx_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [OCC_W-1:0]  occupancy
`ifdef SINK_LATENCY_EN
    ,
    output logic [2*CNT_W-1:0] lat_sum,
    output logic [CNT_W-1:0]   lat_max
`endif
);

    // An all-zero seed would lock the LFSR, so an ID of 255 falls back to seed 1.
    localparam logic [7:0]         LFSR_SEED = (8'(ID + 1) == 8'd0) ? 8'd1 : 8'(ID + 1);
    localparam logic [7:0]         HOSP      = 8'(SINK_HOSP);
    localparam logic [ADDR_SZ-1:0] MY_ADDR   = ADDR_SZ'(ID);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    logic [FLIT_W-1:0] head;
    logic              fifo_full, fifo_empty;
    logic              push, pop, addr_err;
    logic [7:0]        lfsr_q, lfsr_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    logic              fv_q, fv_d;
    logic [CNT_W-1:0]  rx_q, rx_d;
    logic [CNT_W-1:0]  err_q, err_d;

    assign busy_out = fifo_full | reset;
    assign push     = valid_in & ~busy_out;
    assign pop      = ~fifo_empty & (lfsr_q <= HOSP);
    assign addr_err = (head[ADDR_LSB +: ADDR_SZ] != MY_ADDR);

    sink_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FLIT_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (data_in),
        .rdata (head),
        .count (occupancy),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        lfsr_d = lfsr_next(lfsr_q);
        flit_d = flit_q;
        fv_d   = pop;
        rx_d   = rx_q;
        err_d  = err_q;
        if (pop) begin
            flit_d = head;
            if (rx_q != CNT_MAX)              rx_d  = rx_q + 1'b1;
            if (addr_err && err_q != CNT_MAX) err_d = err_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
            flit_q <= '0;
            fv_q   <= 1'b0;
            rx_q   <= '0;
            err_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            flit_q <= flit_d;
            fv_q   <= fv_d;
            rx_q   <= rx_d;
            err_q  <= err_d;
        end
    end

    assign flit_out   = flit_q;
    assign flit_valid = fv_q;
    assign rx_count   = rx_q;
    assign err_count  = err_q;

`ifdef SINK_LATENCY_EN
    // The payload's low CNT_W bits carry the injection timestamp; subtraction wraps mod 2^CNT_W.
    localparam logic [2*CNT_W-1:0] SUM_MAX = '1;

    logic [CNT_W-1:0]   ts_q;
    logic [CNT_W-1:0]   lat_now;
    logic [CNT_W-1:0]   lat_max_q, lat_max_d;
    logic [2*CNT_W-1:0] lat_sum_q, lat_sum_d;
    logic [2*CNT_W:0]   sum_ext;

    assign lat_now = ts_q - head[PL_LSB +: CNT_W];
    assign sum_ext = {1'b0, lat_sum_q} + {{(CNT_W + 1){1'b0}}, lat_now};

    always_comb begin
        lat_sum_d = lat_sum_q;
        lat_max_d = lat_max_q;
        if (pop) begin
            lat_sum_d = sum_ext[2*CNT_W] ? SUM_MAX : sum_ext[2*CNT_W-1:0];
            if (lat_now > lat_max_q) lat_max_d = lat_now;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q      <= '0;
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else begin
            ts_q      <= ts_q + 1'b1;
            lat_sum_q <= lat_sum_d;
            lat_max_q <= lat_max_d;
        end
    end

    assign lat_sum = lat_sum_q;
    assign lat_max = lat_max_q;
`endif

endmodule
